// File: rtl/button_pkg.sv
// Shared types for the push-button front end: per-channel FSM state encoding
// and a small helper used to size the repeat timer.
package button_pkg;

   typedef enum logic [1:0] {
      BC_IDLE,
      BC_PRESSED,
      BC_HELD
   } bc_state_t;

   function automatic int bc_max(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// Button bundle between board pins and the control logic; the conditioner
// is the slave side, the consumer/driver of raw pins is the master side.
interface button_conditioner_if #(
   parameter int N_CH = 4
);
   import button_pkg::*;

   logic [N_CH-1:0] Bi;
   logic [N_CH-1:0] RepeatEn;
   logic [N_CH-1:0] Bo;
   logic [N_CH-1:0] Level;
   logic [N_CH-1:0] Held;
   // Per-channel FSM state, exported for observation only.
   bc_state_t [N_CH-1:0] State;

   modport master (
      output Bi, RepeatEn,
      input  Bo, Level, Held, State
   );

   modport slave (
      input  Bi, RepeatEn,
      output Bo, Level, Held, State
   );

endinterface

// File: rtl/button_channel.sv
// One button channel: 2-FF synchroniser, counter debounce, press/hold FSM
// with a shared delay/repeat timer. Input p is already polarity-corrected.
module button_channel
   import button_pkg::*;
#(
   parameter int DEBOUNCE_CYC = 4,
   parameter int REPEAT_DELAY = 16,
   parameter int REPEAT_RATE  = 4
) (
   input  logic      Clock,
   input  logic      Resetn,
   input  logic      p,
   input  logic      RepeatEn,
   output logic      Bo,
   output logic      Level,
   output logic      Held,
   output bc_state_t State
);

   localparam int TW = $clog2(bc_max(REPEAT_DELAY, REPEAT_RATE) + 1);
   localparam int CW = $clog2(DEBOUNCE_CYC + 1);
   localparam logic [TW-1:0] T_DELAY = TW'(REPEAT_DELAY - 1);
   localparam logic [TW-1:0] T_RATE  = TW'(REPEAT_RATE - 1);
   localparam logic [TW-1:0] T_ONE   = TW'(1);
   localparam logic [CW-1:0] C_LAST  = CW'(DEBOUNCE_CYC - 1);
   localparam logic [CW-1:0] C_ONE   = CW'(1);

   logic          s1;
   logic          s;
   logic [CW-1:0] cnt;
   logic          level_q;
   bc_state_t     state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic          bo_q, bo_d;

   // Debounce: Level only flips after DEBOUNCE_CYC back-to-back disagreeing samples.
   always_ff @(posedge Clock) begin
      if (!Resetn) begin
         s1      <= 1'b0;
         s       <= 1'b0;
         cnt     <= '0;
         level_q <= 1'b0;
      end else begin
         s1 <= p;
         s  <= s1;
         if (s == level_q) begin
            cnt <= '0;
         end else if (cnt == C_LAST) begin
            level_q <= ~level_q;
            cnt     <= '0;
         end else begin
            cnt <= cnt + C_ONE;
         end
      end
   end

   always_ff @(posedge Clock) begin
      if (!Resetn) begin
         state_q <= BC_IDLE;
         timer_q <= '0;
         bo_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         bo_q    <= bo_d;
      end
   end

   // A release seen by the FSM always beats a timer expiry in the same cycle.
   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      bo_d    = 1'b0;
      unique case (state_q)
         BC_IDLE: begin
            if (level_q) begin
               bo_d    = 1'b1;
               timer_d = T_DELAY;
               state_d = BC_PRESSED;
            end
         end
         BC_PRESSED, BC_HELD: begin
            if (!level_q) begin
               state_d = BC_IDLE;
            end else if (timer_q == '0) begin
               state_d = BC_HELD;
               bo_d    = RepeatEn;
               timer_d = T_RATE;
            end else begin
               timer_d = timer_q - T_ONE;
            end
         end
         default: state_d = BC_IDLE;
      endcase
   end

   assign Bo    = bo_q;
   assign Level = level_q;
   // Qualified by Level so Held drops in the same cycle the debounced level falls.
   assign Held  = (state_q == BC_HELD) && level_q;
   assign State = state_q;

endmodule

// File: rtl/button_conditioner.sv
// Multi-channel push-button conditioner: applies input polarity and fans the
// bundle out to independent button_channel instances.
module button_conditioner
   import button_pkg::*;
#(
   parameter int N_CH          = 4,
   parameter int DEBOUNCE_CYC  = 4,
   parameter int REPEAT_DELAY  = 16,
   parameter int REPEAT_RATE   = 4,
   parameter bit ACTIVE_LOW_IN = 1'b1
) (
   input logic                 Clock,
   input logic                 Resetn,
   button_conditioner_if.slave bus
);

   logic [N_CH-1:0]      p;
   logic [N_CH-1:0]      bo;
   logic [N_CH-1:0]      level;
   logic [N_CH-1:0]      held;
   bc_state_t [N_CH-1:0] state;

   assign p = ACTIVE_LOW_IN ? ~bus.Bi : bus.Bi;

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      button_channel #(
         .DEBOUNCE_CYC (DEBOUNCE_CYC),
         .REPEAT_DELAY (REPEAT_DELAY),
         .REPEAT_RATE  (REPEAT_RATE)
      ) u_ch (
         .Clock    (Clock),
         .Resetn   (Resetn),
         .p        (p[i]),
         .RepeatEn (bus.RepeatEn[i]),
         .Bo       (bo[i]),
         .Level    (level[i]),
         .Held     (held[i]),
         .State    (state[i])
      );
   end

   assign bus.Bo    = bo;
   assign bus.Level = level;
   assign bus.Held  = held;
   assign bus.State = state;

endmodule
